// File: rtl/mem_access_unit_if.sv
// Memory-side handshake bundle: address/write data out, read data and ack back.
interface mem_access_unit_if;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_req,
      output mem_we,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_req,
      input  mem_we,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// LC-3 style memory access unit: MAR/MDR registers plus a request/ack
// sequencer with a bounded wait and a sticky timeout flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not busy; MAR/MDR loads and mio_en accepted
// REQ   | first request cycle; wait timer freshly loaded
// WAIT  | request held until ack or wait timer terminal count
// DONE  | one-cycle ready pulse, then back to IDLE
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       bus_in,
   input  logic              ld_mar,
   input  logic              ld_mdr,
   input  logic              mio_en,
   input  logic              r_w,
   mem_access_unit_if.master mem_bus,
   output logic [15:0]       mar_out,
   output logic [15:0]       mdr_out,
   output logic              ready,
   output logic              busy,
   output logic              bus_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Down-counter preset to the allowed number of WAIT cycles; the access
   // aborts on the WAIT cycle that sees a count of one.
   localparam logic [3:0] WAIT_LOAD = 4'(TIMEOUT);

   state_t      state_q, state_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] mdr_q, mdr_d;
   logic        dir_q, dir_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        bus_err_q, bus_err_d;

   logic        mem_req_o;
   logic        mem_we_o;
   logic        ready_o;
   logic        busy_o;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mar_q      <= 16'h0000;
         mdr_q      <= 16'h0000;
         dir_q      <= 1'b0;
         wait_cnt_q <= 4'd0;
         bus_err_q  <= 1'b0;
      end else begin
         mar_q      <= mar_d;
         mdr_q      <= mdr_d;
         dir_q      <= dir_d;
         wait_cnt_q <= wait_cnt_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Next-state and register updates
   always_comb begin
      state_d    = state_q;
      mar_d      = mar_q;
      mdr_d      = mdr_q;
      dir_d      = dir_q;
      wait_cnt_d = wait_cnt_q;
      bus_err_d  = bus_err_q;

      case (state_q)
         IDLE: begin
            if (ld_mar) begin
               mar_d = bus_in;
            end
            // A bus load of MDR is blocked when an access starts, except for
            // a write, which then carries the freshly loaded data.
            if (ld_mdr && (!mio_en || r_w)) begin
               mdr_d = bus_in;
            end
            if (mio_en) begin
               dir_d      = r_w;
               wait_cnt_d = WAIT_LOAD;
               bus_err_d  = 1'b0;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (mem_bus.mem_ack) begin
               if (!dir_q) begin
                  mdr_d = mem_bus.mem_rdata;
               end
               state_d = DONE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_bus.mem_ack) begin
               if (!dir_q) begin
                  mdr_d = mem_bus.mem_rdata;
               end
               state_d = DONE;
            end else if (wait_cnt_q <= 4'd1) begin
               wait_cnt_d = 4'd0;
               bus_err_d  = 1'b1;
               state_d    = DONE;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      ready_o   = 1'b0;
      busy_o    = 1'b1;
      case (state_q)
         IDLE: busy_o = 1'b0;
         REQ, WAIT: begin
            mem_req_o = 1'b1;
            mem_we_o  = dir_q;
         end
         DONE: ready_o = 1'b1;
         default: busy_o = 1'b1;
      endcase
   end

   assign mem_bus.mem_addr  = mar_q;
   assign mem_bus.mem_wdata = mdr_q;
   assign mem_bus.mem_req   = mem_req_o;
   assign mem_bus.mem_we    = mem_we_o;
   assign mar_out           = mar_q;
   assign mdr_out           = mdr_q;
   assign ready             = ready_o;
   assign busy              = busy_o;
   assign bus_err           = bus_err_q;

endmodule
